position_conv_ctrl: RTL

- Sequencing controller for the encoder pulse-to-position conversion path.
- Tracks the pulse count P from incoming encoder steps, wrapping modulo PPR+1.
- Runs a multi-cycle conversion Position = floor(P * 2^W / (PPR+1)) using W-iteration restoring division.
- Publishes each result with a one-cycle valid strobe; sits between the encoder front end and the position consumers.

---
 rtl/position_conv_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/position_conv_ctrl.sv
// position_conv_ctrl
//   Encoder pulse-to-position sequencer. Tracks the pulse count P (wrapping
//   over 0..PPR), and on every count update runs a W-iteration restoring
//   division to publish Position = floor(P * 2^W / (PPR+1)).
//
// Ports
//   CLK        system clock, rising edge
//   RST        asynchronous active-high reset
//   PPR        pulses-per-revolution minus one (live for wrap, latched at start)
//   ENC_A      step strobe (raw quadrature channel A when QUAD_DECODE_EN)
//   ENC_B      direction, 1 = up (raw quadrature channel B when QUAD_DECODE_EN)
//   INDEX      synchronous index pulse, zeroes the count
//   P_count    current pulse count
//   Position   last completed conversion result
//   pos_valid  one-cycle strobe when Position updates
//   busy       high while a conversion is in progress
//
// Build option
//   QUAD_DECODE_EN  when defined, ENC_A/ENC_B are raw quadrature inputs that
//                   go through 2-FF synchronizers and an x4 decoder
//                   (3 cycles pin-to-count latency).
//
// state  | meaning
// S_IDLE | waiting for a pending count update
// S_CALC | W division iterations in progress, busy=1

module position_conv_ctrl #(
  parameter int W = 10
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] PPR,
  input  logic         ENC_A,
  input  logic         ENC_B,
  input  logic         INDEX,
  output logic [W-1:0] P_count,
  output logic [W-1:0] Position,
  output logic         pos_valid,
  output logic         busy
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic {S_IDLE, S_CALC} state_t;

  logic step_s;
  logic up_s;

`ifdef QUAD_DECODE_EN
  logic [1:0] a_sync_q;
  logic [1:0] b_sync_q;
  logic       a_prev_q;
  logic       b_prev_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      a_prev_q <= 1'b0;
      b_prev_q <= 1'b0;
    end else begin
      a_sync_q <= {a_sync_q[0], ENC_A};
      b_sync_q <= {b_sync_q[0], ENC_B};
      a_prev_q <= a_sync_q[1];
      b_prev_q <= b_sync_q[1];
    end
  end

  // Gray sequence AB: 00 -> 10 -> 11 -> 01 -> 00 is A leading B (up).
  // Double changes and no-change fall through to no step.
  always_comb begin
    step_s = 1'b0;
    up_s   = 1'b0;
    case ({a_prev_q, b_prev_q, a_sync_q[1], b_sync_q[1]})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
        step_s = 1'b1;
        up_s   = 1'b1;
      end
      4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
        step_s = 1'b1;
        up_s   = 1'b0;
      end
      default: ;
    endcase
  end
`else
  assign step_s = ENC_A;
  assign up_s   = ENC_B;
`endif

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   pos_q, pos_d;
  logic           valid_q, valid_d;
  logic           pend_q, pend_d;
  logic [W:0]     r_q, r_d;
  logic [W:0]     div_q, div_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [CW-1:0]  iter_q, iter_d;
  logic           sat_q, sat_d;
  logic           upd;
  logic [W:0]     r_shift;
  logic           qbit;

  always_comb begin
    count_d = count_q;
    upd     = 1'b0;
    if (INDEX) begin
      count_d = '0;
      upd     = 1'b1;
    end else if (step_s) begin
      upd = 1'b1;
      if (up_s) begin
        count_d = (count_q >= PPR) ? '0 : count_q + 1'b1;
      end else begin
        count_d = (count_q == '0 || count_q > PPR) ? PPR : count_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    valid_d = 1'b0;
    pend_d  = pend_q | upd;
    r_d     = r_q;
    div_d   = div_q;
    quo_d   = quo_q;
    iter_d  = iter_q;
    sat_d   = sat_q;
    r_shift = {r_q[W-1:0], 1'b0};
    qbit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          // An update on this same edge keeps pending set for a follow-on run.
          pend_d  = upd;
          r_d     = {1'b0, count_q};
          div_d   = {1'b0, PPR} + {{W{1'b0}}, 1'b1};
          // A count beyond the divisor means a quotient of 2^W or more.
          sat_d   = (count_q > PPR);
          iter_d  = CW'(W);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (r_shift >= div_q) begin
          r_d  = r_shift - div_q;
          qbit = 1'b1;
        end else begin
          r_d  = r_shift;
        end
        quo_d  = {quo_q[W-2:0], qbit};
        iter_d = iter_q - 1'b1;
        if (iter_q == CW'(1)) begin
          pos_d   = sat_q ? '1 : {quo_q[W-2:0], qbit};
          valid_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      count_q <= '0;
      pos_q   <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      r_q     <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      iter_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pos_q   <= pos_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      r_q     <= r_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      iter_q  <= iter_d;
      sat_q   <= sat_d;
    end
  end

  assign P_count   = count_q;
  assign Position  = pos_q;
  assign pos_valid = valid_q;
  assign busy      = (state_q == S_CALC);

endmodule
